// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: register offsets, STATUS layout and the timer type.
package mmio_pkg;

    typedef logic [63:0] mtime_t;
    typedef logic [2:0]  mmio_off_t;

    localparam mmio_off_t MMIO_OFF_CONSOLE_TX  = 3'd0;
    localparam mmio_off_t MMIO_OFF_STATUS      = 3'd1;
    localparam mmio_off_t MMIO_OFF_MTIME_LO    = 3'd2;
    localparam mmio_off_t MMIO_OFF_MTIME_HI    = 3'd3;
    localparam mmio_off_t MMIO_OFF_MTIMECMP_LO = 3'd4;
    localparam mmio_off_t MMIO_OFF_MTIMECMP_HI = 3'd5;
    localparam mmio_off_t MMIO_OFF_TOHOST      = 3'd6;
    localparam mmio_off_t MMIO_OFF_RESERVED    = 3'd7;

    localparam int STATUS_CNT_W     = 8;
    localparam int STATUS_EMPTY_BIT = 8;
    localparam int STATUS_FULL_BIT  = 9;
    localparam int STATUS_OVF_BIT   = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is left unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO window beside the DCCM: console TX FIFO, 64-bit mtime/mtimecmp timer with interrupt, and tohost.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int PRESCALE   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] raddr,
    input  logic            rvalid_in,
    output logic [XLEN-1:0] rdata,
    output logic            rvalid_out,
    input  logic [XLEN-1:0] waddr,
    input  logic            wen,
    input  logic [XLEN-1:0] wdata,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            timer_irq,
    output logic            sim_done,
    output logic [XLEN-1:0] sim_code
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    mmio_off_t r_off, w_off;
    logic      wr_console, wr_status, wr_mtime_lo, wr_mtime_hi;
    logic      wr_cmp_lo, wr_cmp_hi, wr_tohost;

    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    logic            overflow_q, overflow_d;
    mtime_t          mtime_q, mtime_d, mtime_inc;
    mtime_t          mtimecmp_q, mtimecmp_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic            tick;
    logic            irq_q, irq_d;
    logic            sim_done_q, sim_done_d;
    logic [XLEN-1:0] sim_code_q, sim_code_d;
    logic [XLEN-1:0] rdata_q, rdata_d, rd_word;
    logic            rvalid_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{raddr[XLEN-1:5], raddr[1:0], waddr[XLEN-1:5], waddr[1:0]};

    assign r_off       = raddr[4:2];
    assign w_off       = waddr[4:2];
    assign wr_console  = wen && (w_off == MMIO_OFF_CONSOLE_TX);
    assign wr_status   = wen && (w_off == MMIO_OFF_STATUS);
    assign wr_mtime_lo = wen && (w_off == MMIO_OFF_MTIME_LO);
    assign wr_mtime_hi = wen && (w_off == MMIO_OFF_MTIME_HI);
    assign wr_cmp_lo   = wen && (w_off == MMIO_OFF_MTIMECMP_LO);
    assign wr_cmp_hi   = wen && (w_off == MMIO_OFF_MTIMECMP_HI);
    assign wr_tohost   = wen && (w_off == MMIO_OFF_TOHOST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_console),
        .data_i  (wdata[7:0]),
        .pop_i   (tx_ready),
        .data_o  (tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign tx_valid   = !fifo_empty;
    assign rdata      = rdata_q;
    assign rvalid_out = rvalid_q;
    assign timer_irq  = irq_q;
    assign sim_done   = sim_done_q;
    assign sim_code   = sim_code_q;

    always_comb begin
        // A new overflow is applied after the W1C so it wins a same-cycle clear.
        overflow_d = overflow_q;
        if (wr_status && wdata[STATUS_OVF_BIT]) overflow_d = 1'b0;
        if (wr_console && fifo_full && !tx_ready) overflow_d = 1'b1;

        tick      = (presc_q == PS_W'(PRESCALE - 1));
        presc_d   = tick ? '0 : presc_q + PS_W'(1);
        mtime_inc = mtime_q + mtime_t'(tick);

        // A half written by software replaces that half; no carry crosses into the other half.
        mtime_d = mtime_inc;
        if (wr_mtime_lo)      mtime_d = {mtime_q[63:32], wdata[31:0]};
        else if (wr_mtime_hi) mtime_d = {wdata[31:0], mtime_inc[31:0]};

        mtimecmp_d = mtimecmp_q;
        if (wr_cmp_lo)      mtimecmp_d = {mtimecmp_q[63:32], wdata[31:0]};
        else if (wr_cmp_hi) mtimecmp_d = {wdata[31:0], mtimecmp_q[31:0]};

        irq_d = (mtime_q >= mtimecmp_q);

        sim_done_d = sim_done_q;
        sim_code_d = sim_code_q;
        if (wr_tohost && !sim_done_q) begin
            sim_done_d = 1'b1;
            sim_code_d = wdata;
        end

        rd_word = '0;
        case (r_off)
            MMIO_OFF_STATUS: begin
                rd_word[STATUS_CNT_W-1:0]  = STATUS_CNT_W'(fifo_count);
                rd_word[STATUS_EMPTY_BIT]  = fifo_empty;
                rd_word[STATUS_FULL_BIT]   = fifo_full;
                rd_word[STATUS_OVF_BIT]    = overflow_q;
            end
            MMIO_OFF_MTIME_LO:    rd_word[31:0] = mtime_q[31:0];
            MMIO_OFF_MTIME_HI:    rd_word[31:0] = mtime_q[63:32];
            MMIO_OFF_MTIMECMP_LO: rd_word[31:0] = mtimecmp_q[31:0];
            MMIO_OFF_MTIMECMP_HI: rd_word[31:0] = mtimecmp_q[63:32];
            default:              rd_word = '0;
        endcase
        rdata_d = rvalid_in ? rd_word : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            presc_q    <= '0;
            irq_q      <= 1'b0;
            sim_done_q <= 1'b0;
            sim_code_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            presc_q    <= presc_d;
            irq_q      <= irq_d;
            sim_done_q <= sim_done_d;
            sim_code_q <= sim_code_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_in;
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Randomized and directed bench for mmio_responder, checked against a queue/integer reference model.
module tb_mmio_responder;
    localparam int DEPTH    = 16;
    localparam int PRESCALE = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raddr, waddr, wdata, rdata, sim_code;
    logic        rvalid_in, rvalid_out, wen, tx_ready, tx_valid, timer_irq, sim_done;
    logic [7:0]  tx_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mmio_responder #(
        .XLEN       (32),
        .FIFO_DEPTH (DEPTH),
        .PRESCALE   (PRESCALE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raddr      (raddr),
        .rvalid_in  (rvalid_in),
        .rdata      (rdata),
        .rvalid_out (rvalid_out),
        .waddr      (waddr),
        .wen        (wen),
        .wdata      (wdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .timer_irq  (timer_irq),
        .sim_done   (sim_done),
        .sim_code   (sim_code)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    byte unsigned    m_q[$];
    bit              m_ovf, m_irq, m_done, m_rvalid;
    longint unsigned m_mtime, m_cmp;
    logic [31:0]     m_code, m_rdata;
    int              m_presc;

    function automatic logic [31:0] m_read(input int off);
        logic [31:0] v;
        v = 32'd0;
        case (off)
            1: v = m_q.size() + ((m_q.size() == 0) ? 32'h100 : 0)
                   + ((m_q.size() == DEPTH) ? 32'h200 : 0) + (m_ovf ? 32'h400 : 0);
            2: v = m_mtime[31:0];
            3: v = m_mtime[63:32];
            4: v = m_cmp[31:0];
            5: v = m_cmp[63:32];
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] addr_of(input int off);
        logic [31:0] a;
        a = $urandom();
        a[4:2] = off[2:0];
        return a;
    endfunction

    task automatic step(input bit r, input bit rv, input logic [31:0] ra, input bit we,
                        input logic [31:0] wa, input logic [31:0] wd, input bit rdy);
        int woff, roff;
        bit pop, full_pre, tick, irq_n;
        longint unsigned inc;
        logic [31:0] lo_inc;
        rst = r; rvalid_in = rv; raddr = ra; wen = we; waddr = wa; wdata = wd; tx_ready = rdy;
        woff = int'(wa[4:2]);
        roff = int'(ra[4:2]);
        if (r) begin
            m_q.delete();
            m_ovf = 0; m_irq = 0; m_done = 0; m_rvalid = 0;
            m_mtime = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
            m_code = 0; m_rdata = 0; m_presc = 0;
        end else begin
            if (rv) m_rdata = m_read(roff);
            m_rvalid = rv;
            irq_n    = (m_mtime >= m_cmp);
            full_pre = (m_q.size() == DEPTH);
            pop      = rdy && (m_q.size() != 0);
            tick     = (m_presc == PRESCALE - 1);
            m_presc  = tick ? 0 : m_presc + 1;
            inc      = m_mtime + (tick ? 1 : 0);
            lo_inc   = m_mtime[31:0] + (tick ? 32'd1 : 32'd0);
            if (pop) void'(m_q.pop_front());
            if (we && woff == 0) begin
                if (!full_pre || pop) m_q.push_back(wd[7:0]);
                else m_ovf = 1;
            end
            if (we && woff == 1 && wd[10]) m_ovf = 0;
            if (we && woff == 2)      m_mtime = {m_mtime[63:32], wd};
            else if (we && woff == 3) m_mtime = {wd, lo_inc};
            else                      m_mtime = inc;
            if (we && woff == 4) m_cmp = {m_cmp[63:32], wd};
            if (we && woff == 5) m_cmp = {wd, m_cmp[31:0]};
            if (we && woff == 6 && !m_done) begin
                m_done = 1;
                m_code = wd;
            end
            m_irq = irq_n;
        end
        @(posedge clk);
        #1;
        check("rvalid_out", rvalid_out, m_rvalid);
        check("rdata", rdata, m_rdata);
        check("tx_valid", tx_valid, (m_q.size() != 0));
        if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
        check("timer_irq", timer_irq, m_irq);
        check("sim_done", sim_done, m_done);
        check("sim_code", sim_code, m_code);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic wr(input int off, input logic [31:0] d, input bit rdy);
        step(0, 0, 0, 1, addr_of(off), d, rdy);
    endtask
    task automatic rd(input int off, input bit rdy);
        step(0, 1, addr_of(off), 0, 0, 0, rdy);
    endtask
    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        int k;
        rst = 1; rvalid_in = 0; raddr = 0; wen = 0; waddr = 0; wdata = 0; tx_ready = 0;

        do_reset();
        check("reset_rvalid", rvalid_out, 1'b0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_tx_valid", tx_valid, 1'b0);

        // Console stream ordering
        wr(0, 32'h41, 1);
        check("tx_first", tx_data, 8'h41);
        wr(0, 32'h42, 1);
        check("tx_second", tx_data, 8'h42);
        idle(1);
        check("tx_drained", tx_valid, 1'b0);

        // Fill past full, then clear overflow
        for (int i = 0; i < DEPTH + 1; i++) wr(0, 32'(i), 0);
        rd(1, 0);
        check("status_full_ovf", rdata, 32'h610);
        wr(1, 32'h400, 0);
        rd(1, 0);
        check("status_ovf_clr", rdata, 32'h210);
        for (int i = 0; i < DEPTH; i++) idle(1);

        // Read STATUS while pushing: old count returned
        step(0, 1, addr_of(1), 1, addr_of(0), 32'h55, 0);
        check("rw_same_rvalid", rvalid_out, 1'b1);
        check("rw_same_count", rdata[7:0], 8'd0);
        idle(1);

        // Timer compare and interrupt latency
        do_reset();
        wr(5, 32'd0, 0);
        wr(4, 32'd5, 0);
        wr(2, 32'd0, 0);
        k = 0;
        while (k < 20) begin
            idle(0);
            k++;
            if (timer_irq) break;
        end
        check("irq_latency", k, 6);
        wr(5, 32'd1, 0);
        idle(0);
        check("irq_cleared", timer_irq, 1'b0);

        // Low-half carry into high half
        wr(3, 32'd0, 0);
        wr(2, 32'hFFFF_FFFF, 0);
        idle(0);
        rd(2, 0);
        check("mtime_lo_wrap", rdata, 32'd0);
        rd(3, 0);
        check("mtime_hi_carry", rdata, 32'd1);

        // tohost is write-once until reset
        wr(6, 32'h1, 0);
        wr(6, 32'h3, 0);
        check("tohost_code", sim_code, 32'h1);
        check("tohost_done", sim_done, 1'b1);
        do_reset();
        check("tohost_rst_done", sim_done, 1'b0);
        check("tohost_rst_code", sim_code, 32'h0);

        // Back-to-back reads, reserved reads as 0
        rd(2, 0);
        check("b2b_rvalid0", rvalid_out, 1'b1);
        rd(3, 0);
        check("b2b_rvalid1", rvalid_out, 1'b1);
        rd(7, 0);
        check("b2b_rvalid2", rvalid_out, 1'b1);
        check("b2b_reserved", rdata, 32'd0);

        // Reset discards an in-flight read
        step(1, 1, addr_of(2), 0, 0, 0, 0);
        check("rst_inflight", rvalid_out, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit r, rv, we, rdy;
            int off;
            r   = ($urandom_range(0, 299) == 0);
            rv  = $urandom_range(0, 1) == 1;
            we  = $urandom_range(0, 1) == 1;
            rdy = ($urandom_range(0, 2) == 0);
            off = (we && $urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 7));
            step(r, rv, addr_of(int'($urandom_range(0, 7))), we, addr_of(off), $urandom(), rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
